// File: rtl/zports_if.sv
// zports_if: ZX-bus decoder raw port-write bus plus read-back data.
// master = bus decoder side, slave = zports register block.
interface zports_if;
  logic       ports_wrena;
  logic       ports_wrstb_n;
  logic [1:0] ports_addr;
  logic [7:0] ports_wrdata;
  logic [7:0] ports_rddata;

  modport master (
    output ports_wrena,
    output ports_wrstb_n,
    output ports_addr,
    output ports_wrdata,
    input  ports_rddata
  );

  modport slave (
    input  ports_wrena,
    input  ports_wrstb_n,
    input  ports_addr,
    input  ports_wrdata,
    output ports_rddata
  );
endinterface

// File: rtl/zports.sv
// zports: CONFIG / INT_STATUS / INT_MASK registers behind the ZX-bus decoder.
// Ports: fclk, rst (sync, active high); ports (zports_if.slave) raw write
//   bus + combinational read data; rommap_win/ena, w5300_ports, chip
//   resets out; w5300_int_n / sl811_intrq async in; int_n registered out.
module zports (
  input  logic       fclk,
  input  logic       rst,
  zports_if.slave    ports,
  output logic [1:0] rommap_win,
  output logic       rommap_ena,
  output logic       w5300_ports,
  output logic       w5300_rst_n,
  output logic       sl811_rst_n,
  input  logic       w5300_int_n,
  input  logic       sl811_intrq,
  output logic       int_n
);

  localparam logic [1:0] A_CFG  = 2'b01;
  localparam logic [1:0] A_STAT = 2'b10;
  localparam logic [1:0] A_MASK = 2'b11;

  // Write strobe synchroniser, [0]=s1 .. [2]=s3.
  // Cleared to 0 so a strobe already low at release gives no write.
  logic [2:0] stb_sync;
  logic       wr_start;
  logic       wr_go;
  logic       wr_cfg;
  logic       wr_stat;
  logic       wr_mask;

  always_ff @(posedge fclk) begin
    if (rst) begin
      stb_sync <= '0;
    end else begin
      stb_sync <= {stb_sync[1:0], ports.ports_wrstb_n};
    end
  end

  assign wr_start = stb_sync[2] & ~stb_sync[1];
  assign wr_go    = wr_start & ports.ports_wrena;

  always_comb begin
    wr_cfg  = 1'b0;
    wr_stat = 1'b0;
    wr_mask = 1'b0;
    if (wr_go) begin
      unique case (1'b1)
        (ports.ports_addr == A_CFG):  wr_cfg  = 1'b1;
        (ports.ports_addr == A_STAT): wr_stat = 1'b1;
        (ports.ports_addr == A_MASK): wr_mask = 1'b1;
        default: ;
      endcase
    end
  end

  // Data bits 7:6 have no home in any register.
  logic unused_wrdata;
  assign unused_wrdata = ^ports.ports_wrdata[7:6];

  // CONFIG
  logic [5:0] cfg;

  always_ff @(posedge fclk) begin
    if (rst) begin
      cfg <= '0;
    end else if (wr_cfg) begin
      cfg <= ports.ports_wrdata[5:0];
    end
  end

  assign rommap_ena  = cfg[0];
  assign rommap_win  = cfg[2:1];
  assign w5300_ports = cfg[3];
  assign w5300_rst_n = cfg[4];
  assign sl811_rst_n = cfg[5];

  // Interrupt sources, bit0 = W5300, bit1 = SL811, active high.
  logic [1:0] irq_lvl;
  logic [1:0] irq_s1;
  logic [1:0] irq_s2;
  logic [1:0] irq_hist;
  logic [1:0] irq_rise;

  assign irq_lvl = {sl811_intrq, ~w5300_int_n};

  always_ff @(posedge fclk) begin
    if (rst) begin
      irq_s1   <= '0;
      irq_s2   <= '0;
      irq_hist <= '0;
    end else begin
      irq_s1   <= irq_lvl;
      irq_s2   <= irq_s1;
      irq_hist <= irq_s2;
    end
  end

  assign irq_rise = irq_s2 & ~irq_hist;

  // Pending / mask. A same-cycle edge beats a W1C clear.
  logic [1:0] pend;
  logic [1:0] mask;
  logic [1:0] pend_clr;
  logic [1:0] pend_nxt;

  always_comb begin
    pend_clr = 2'b00;
    if (wr_stat) begin
      pend_clr = ports.ports_wrdata[1:0];
    end
    pend_nxt = (pend & ~pend_clr) | irq_rise;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      mask <= '0;
    end else if (wr_mask) begin
      mask <= ports.ports_wrdata[1:0];
    end
  end

  // int_n follows the registered state one cycle later.
  always_ff @(posedge fclk) begin
    if (rst) begin
      int_n <= 1'b1;
    end else begin
      int_n <= ~|(pend & mask);
    end
  end

  // Read mux
  always_comb begin
    ports.ports_rddata = 8'hFF;
    unique case (ports.ports_addr)
      2'b00:  ports.ports_rddata = 8'hFF;
      A_CFG:  ports.ports_rddata = {2'b00, cfg};
      A_STAT: ports.ports_rddata = {4'h0, irq_s2, pend};
      A_MASK: ports.ports_rddata = {6'h00, mask};
      default: ports.ports_rddata = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_zports.sv
// tb_zports: randomized scoreboard bench for zports.
// Stimulus pushes timed expectations; a monitor compares on negedge.
module tb_zports;

  logic       fclk = 1'b0;
  logic       rst;
  logic [1:0] rommap_win;
  logic       rommap_ena;
  logic       w5300_ports;
  logic       w5300_rst_n;
  logic       sl811_rst_n;
  logic       w5300_int_n;
  logic       sl811_intrq;
  logic       int_n;

  always #5 fclk = ~fclk;

  zports_if ports ();

  zports dut (
    .fclk        (fclk),
    .rst         (rst),
    .ports       (ports),
    .rommap_win  (rommap_win),
    .rommap_ena  (rommap_ena),
    .w5300_ports (w5300_ports),
    .w5300_rst_n (w5300_rst_n),
    .sl811_rst_n (sl811_rst_n),
    .w5300_int_n (w5300_int_n),
    .sl811_intrq (sl811_intrq),
    .int_n       (int_n)
  );

  typedef struct {
    int         due;
    bit         is_rd;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t keep_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge fclk) cyc <= cyc + 1;

  // Reference model of the architectural state seen at each negedge.
  logic [5:0] m_cfg;
  logic [1:0] m_pend;
  logic [1:0] m_mask;
  logic [1:0] m_raw;

  function automatic logic [7:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 8'hFF;
      2'd1:    return {2'b00, m_cfg};
      2'd2:    return {4'h0, m_raw, m_pend};
      default: return {6'h00, m_mask};
    endcase
  endfunction

  function automatic logic m_intn();
    return ~|(m_pend & m_mask);
  endfunction

  function automatic logic [7:0] m_out(input logic in_n);
    return {1'b0, in_n, m_cfg};
  endfunction

  // Monitor
  always @(negedge fclk) begin
    logic [7:0] act;
    #2;
    keep_q = {};
    foreach (sbq[i]) begin
      if (sbq[i].due == cyc) begin
        if (sbq[i].is_rd) act = ports.ports_rddata;
        else act = {1'b0, int_n, sl811_rst_n, w5300_rst_n,
                    w5300_ports, rommap_win, rommap_ena};
        n_tests++;
        if (act !== sbq[i].exp) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %02h want %02h",
                   sbq[i].name, cyc, act, sbq[i].exp);
        end
      end else if (sbq[i].due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s missed: due %0d now %0d",
                 sbq[i].name, sbq[i].due, cyc);
      end else begin
        keep_q.push_back(sbq[i]);
      end
    end
    sbq = keep_q;
  end

  task automatic tick();
    @(negedge fclk);
  endtask

  task automatic push(input int due, input bit rd,
                      input logic [7:0] e, input string nm);
    exp_t x;
    x.due   = due;
    x.is_rd = rd;
    x.exp   = e;
    x.name  = nm;
    sbq.push_back(x);
  endtask

  task automatic chk_rd(input logic [1:0] a, input string nm);
    ports.ports_addr = a;
    push(cyc, 1'b1, m_rd(a), nm);
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < 4; a++) begin
      chk_rd(a[1:0], nm);
      tick();
    end
  endtask

  // Strobe low 3 cycles, high 2 cycles; effect lands 3 edges after fall.
  task automatic wr(input logic [1:0] a, input logic [7:0] d,
                    input logic en, input string nm);
    int   k;
    logic i0;
    k  = cyc;
    i0 = m_intn();
    ports.ports_addr    = a;
    ports.ports_wrdata  = d;
    ports.ports_wrena   = en;
    ports.ports_wrstb_n = 1'b0;
    push(k + 2, 1'b0, m_out(i0), {nm, "_pre"});
    repeat (3) tick();
    if (en) begin
      case (a)
        2'd1: m_cfg = d[5:0];
        2'd2: m_pend = m_pend & ~d[1:0];
        2'd3: m_mask = d[1:0];
        default: ;
      endcase
    end
    push(k + 3, 1'b0, m_out(i0), nm);
    push(k + 4, 1'b0, m_out(m_intn()), {nm, "_int"});
    ports.ports_wrstb_n = 1'b1;
    ports.ports_wrdata  = 8'($urandom);
    ports.ports_wrena   = 1'($urandom);
    repeat (2) tick();
  endtask

  // Drive interrupt source src to active-high level lvl.
  task automatic irq(input int src, input logic lvl);
    logic old;
    logic i0;
    old = m_raw[src];
    if (src == 0) w5300_int_n = ~lvl;
    else sl811_intrq = lvl;
    repeat (2) tick();
    m_raw[src] = lvl;
    chk_rd(2'd2, "irq_sync");
    tick();
    i0 = m_intn();
    if (lvl && !old) m_pend[src] = 1'b1;
    chk_rd(2'd2, "irq_pend");
    push(cyc, 1'b0, m_out(i0), "irq_out");
    push(cyc + 1, 1'b0, m_out(m_intn()), "irq_int");
    tick();
  endtask

  task automatic do_reset(input bit strobe_low);
    int         r;
    logic [1:0] lv;
    if (strobe_low) begin
      ports.ports_addr    = 2'd1;
      ports.ports_wrdata  = 8'hA5;
      ports.ports_wrena   = 1'b1;
      ports.ports_wrstb_n = 1'b0;
      tick();
    end
    rst = 1'b1;
    repeat (2) tick();
    rst    = 1'b0;
    m_cfg  = '0;
    m_pend = '0;
    m_mask = '0;
    m_raw  = '0;
    r  = cyc;
    lv = {sl811_intrq, ~w5300_int_n};
    push(r, 1'b0, m_out(1'b1), "rst_out0");
    repeat (2) tick();
    m_raw = lv;
    push(cyc, 1'b0, m_out(1'b1), "rst_out2");
    tick();
    m_pend = lv;
    push(cyc, 1'b0, m_out(1'b1), "rst_out3");
    repeat (2) tick();
    ports.ports_wrstb_n = 1'b1;
    repeat (2) tick();
    read_all("rst_rd");
  endtask

  initial begin
    int   k;
    logic i0;
    rst                 = 1'b1;
    ports.ports_wrena   = 1'b0;
    ports.ports_wrstb_n = 1'b1;
    ports.ports_addr    = 2'd0;
    ports.ports_wrdata  = 8'h00;
    w5300_int_n         = 1'b1;
    sl811_intrq         = 1'b0;
    m_cfg  = '0;
    m_pend = '0;
    m_mask = '0;
    m_raw  = '0;

    do_reset(1'b0);

    wr(2'd1, 8'hFF, 1'b1, "cfg_ff");
    chk_rd(2'd1, "cfg_rd");
    tick();
    wr(2'd1, 8'h00, 1'b0, "cfg_noena");
    chk_rd(2'd1, "cfg_noena_rd");
    tick();
    wr(2'd0, 8'h12, 1'b1, "addr0_wr");
    read_all("addr0_rd");

    wr(2'd3, 8'h03, 1'b1, "mask3");
    irq(0, 1'b1);
    wr(2'd2, 8'h01, 1'b1, "w1c0");
    read_all("w1c0_rd");
    irq(0, 1'b0);

    // SL811 edge and W1C of bit 1 land on the same edge.
    k  = cyc;
    i0 = m_intn();
    sl811_intrq         = 1'b1;
    ports.ports_addr    = 2'd2;
    ports.ports_wrdata  = 8'h02;
    ports.ports_wrena   = 1'b1;
    ports.ports_wrstb_n = 1'b0;
    repeat (2) tick();
    m_raw[1] = 1'b1;
    tick();
    m_pend[1] = 1'b1;
    push(k + 3, 1'b0, m_out(i0), "coll_out");
    push(k + 4, 1'b0, m_out(m_intn()), "coll_int");
    ports.ports_wrstb_n = 1'b1;
    repeat (2) tick();
    chk_rd(2'd2, "coll_status");
    tick();

    irq(0, 1'b1);
    wr(2'd3, 8'h00, 1'b1, "mask0");
    read_all("mask0_rd");
    wr(2'd3, 8'h02, 1'b1, "mask2");
    read_all("mask2_rd");

    do_reset(1'b1);
    wr(2'd1, 8'h5A, 1'b1, "cfg_after_rst");
    read_all("after_rst_rd");

    for (int n = 0; n < 120; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 6) begin
        wr(2'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0), "rnd_wr");
      end else begin
        int s;
        s = $urandom_range(0, 1);
        irq(s, ~m_raw[s]);
      end
      chk_rd(2'($urandom), "rnd_rd");
      tick();
    end
    read_all("final_rd");

    repeat (4) tick();
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d left, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
